// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    // Transfer phases of the requester FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_t;

    // Wait counter width, wide enough for the largest timeout of 255.
    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/apb_sel_decode.sv
// Combinational address decode: subordinate index field to one-hot select, plus legality.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows the address input.
// Ports: addr (full address in), sel (one-hot select out, all-zero when illegal),
//        legal (high when every address bit above the index field is zero).
module apb_sel_decode #(
    parameter int AddrWidth   = 16,
    parameter int NumSubs     = 4,
    parameter int SubAddrBits = 4
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [NumSubs-1:0]   sel,
    output logic                 legal
);

    localparam int IdxW  = (NumSubs > 1) ? $clog2(NumSubs) : 1;
    localparam int HiLsb = SubAddrBits + IdxW;

    logic [IdxW-1:0] idx;

    assign idx   = addr[SubAddrBits +: IdxW];
    // Anything set above the index field points outside every window.
    assign legal = ((addr >> HiLsb) == '0);

    always_comb begin
        sel = '0;
        if (legal) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: accepts a command, runs SETUP/ACCESS, holds a response.
// Latency: 3 cycles accept-to-rspValid minimum (SETUP, ACCESS, RESP); 1 cycle for illegal decode.
// Backpressure: cmdReady only in IDLE; response held in RESP until rspReady; ACCESS times out.
// Ports: cmd* (command handshake), rsp* (response handshake),
//        sel/enable/write/addr/wData (APB requester outputs, all registered),
//        ready/rData/subErr (APB subordinate returns).
module apb_requester
    import apb_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int NumSubs       = 4,
    parameter int SubAddrBits   = 4,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic                 cmdWrite,
    input  logic [AddrWidth-1:0] cmdAddr,
    input  logic [DataWidth-1:0] cmdWData,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [DataWidth-1:0] rspRData,
    output logic                 rspErr,
    output logic [NumSubs-1:0]   sel,
    output logic                 enable,
    output logic                 write,
    output logic [AddrWidth-1:0] addr,
    output logic [DataWidth-1:0] wData,
    input  logic                 ready,
    input  logic [DataWidth-1:0] rData,
    input  logic                 subErr
);

    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'((1 << SubAddrBits) - 1);
    localparam logic [TO_CNT_W-1:0]  ToLast  = TO_CNT_W'(TimeoutCycles - 1);

    apb_req_state_t        state_q;
    apb_req_state_t        state_d;
    logic [TO_CNT_W-1:0]   wait_cnt;
    logic [NumSubs-1:0]    dec_sel;
    logic                  dec_legal;
    logic                  timeout;

    apb_sel_decode #(
        .AddrWidth  (AddrWidth),
        .NumSubs    (NumSubs),
        .SubAddrBits(SubAddrBits)
    ) u_dec (
        .addr (cmdAddr),
        .sel  (dec_sel),
        .legal(dec_legal)
    );

    assign cmdReady = (state_q == IDLE);
    // Timeout only fires when the subordinate is still stalling; ready wins a tie.
    assign timeout  = !ready && (wait_cnt == ToLast);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmdValid) state_d = dec_legal ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (ready || timeout) state_d = RESP;
            RESP:    if (rspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // write/addr/wData double as the captured command; they are loaded only on
    // acceptance, so they naturally hold their last values outside a transfer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sel      <= '0;
            enable   <= 1'b0;
            write    <= 1'b0;
            addr     <= '0;
            wData    <= '0;
            rspValid <= 1'b0;
            rspRData <= '0;
            rspErr   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmdValid) begin
                        write    <= cmdWrite;
                        addr     <= cmdAddr & OffMask;
                        wData    <= cmdWData;
                        wait_cnt <= '0;
                        if (dec_legal) begin
                            sel <= dec_sel;
                        end else begin
                            rspValid <= 1'b1;
                            rspErr   <= 1'b1;
                            rspRData <= '0;
                        end
                    end
                end
                SETUP: begin
                    enable <= 1'b1;
                end
                ACCESS: begin
                    if (ready || timeout) begin
                        sel      <= '0;
                        enable   <= 1'b0;
                        rspValid <= 1'b1;
                        rspErr   <= ready ? subErr : 1'b1;
                        rspRData <= (ready && !write) ? rData : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
